// File: rtl/dtc_pkg.sv
// Shared types and defaults for the DTC transmit-path sequencer.
package dtc_pkg;

  localparam int DTC_WORD_BITS = 256;
  localparam int DTC_NUM_WORDS = 24;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    FILL,
    FLUSH
  } dtc_state_t;

  typedef logic bank_t;

endpackage

// File: rtl/dtc_pingpong_ctrl.sv
// DTC transmit sequencer: walks the packet BRAM, times the serializer
// load/shift and ping-pongs two 1-bit FIFO banks so that one bank fills
// from the serializer while the other drains onto the serial line.
module dtc_pingpong_ctrl
  import dtc_pkg::*;
#(
  parameter int WORD_BITS = DTC_WORD_BITS,
  parameter int NUM_WORDS = DTC_NUM_WORDS,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              ser_load,
  output logic              ser_shift,
  output logic              wr_en_0,
  output logic              wr_en_1,
  output logic              rd_en_0,
  output logic              rd_en_1,
  input  logic              full_0,
  input  logic              empty_0,
  input  logic              full_1,
  input  logic              empty_1,
  output logic              out_sel,
  output logic              out_valid,
  output logic              frame_done,
  output logic              fill_bank,
  output logic              ovf_err,
  output logic              udf_err
);

  dtc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             drain_pending;
  logic             last_drain_d;

  bank_t drain_bank;
  logic  cnt_last;
  logic  addr_last;
  logic  fill_cyc;
  logic  drain_cyc;
  logic  wr_blocked;
  logic  rd_blocked;

  assign drain_bank = bank_t'(~fill_bank);
  assign cnt_last   = (cnt == CNT_W'(WORD_BITS - 1));
  assign addr_last  = (bram_addr == ADDR_W'(NUM_WORDS - 1));
  assign fill_cyc   = (state == FILL);
  assign drain_cyc  = (fill_cyc && drain_pending) || (state == FLUSH);

  // Strobes are gated by the live FIFO flags so a full/empty bank is never touched
  assign wr_en_0 = fill_cyc && (fill_bank == 1'b0) && !full_0;
  assign wr_en_1 = fill_cyc && (fill_bank == 1'b1) && !full_1;
  assign rd_en_0 = drain_cyc && (drain_bank == 1'b0) && !empty_0;
  assign rd_en_1 = drain_cyc && (drain_bank == 1'b1) && !empty_1;

  assign wr_blocked = fill_cyc && (fill_bank ? full_1 : full_0);
  assign rd_blocked = drain_cyc && (drain_bank ? empty_1 : empty_0);

  // Frame sequencer: state, bit counter, address walk, bank swap and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bram_addr     <= '0;
      fill_bank     <= 1'b0;
      drain_pending <= 1'b0;
      bram_en       <= 1'b0;
      ser_load      <= 1'b0;
      ser_shift     <= 1'b0;
    end else begin
      bram_en   <= 1'b0;
      ser_load  <= 1'b0;
      ser_shift <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= FETCH;
            bram_en <= 1'b1;
          end
        end
        FETCH: begin
          state    <= LOAD;
          ser_load <= 1'b1;
        end
        LOAD: begin
          state     <= FILL;
          ser_shift <= 1'b1;
          cnt       <= '0;
          bram_addr <= addr_last ? '0 : bram_addr + ADDR_W'(1);
        end
        FILL: begin
          if (cnt_last) begin
            cnt           <= '0;
            fill_bank     <= ~fill_bank;
            drain_pending <= 1'b1;
            if (enable) begin
              state   <= FETCH;
              bram_en <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end else begin
            cnt       <= cnt + CNT_W'(1);
            ser_shift <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_last) begin
            cnt           <= '0;
            drain_pending <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial-line side: valid follows the FIFO read latency, frame strobe trails the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sel      <= 1'b0;
      last_drain_d <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      out_valid    <= rd_en_0 | rd_en_1;
      last_drain_d <= drain_cyc && cnt_last;
      frame_done   <= last_drain_d;
      if (drain_cyc) begin
        out_sel <= drain_bank;
      end
    end
  end

  // Sticky error flags for writes into a full bank and reads from an empty bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_blocked) begin
        ovf_err <= 1'b1;
      end
      if (rd_blocked) begin
        udf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dtc_pingpong_ctrl.sv
// Directed bench for dtc_pingpong_ctrl with an 8-bit word, 3-word BRAM,
// a model serializer and two depth-8 model FIFOs around the sequencer.
module tb_dtc_pingpong_ctrl;
  import dtc_pkg::*;

  localparam int WB = 8;
  localparam int NW = 3;
  localparam int AW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic          ser_load, ser_shift;
  logic          wr_en_0, wr_en_1, rd_en_0, rd_en_1;
  logic          full_0, empty_0, full_1, empty_1;
  logic          out_sel, out_valid, frame_done, fill_bank;
  logic          ovf_err, udf_err;
  logic          force_full0, force_empty1;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int edge_cnt  = 0;
  int base      = 0;

  always #5 clk = ~clk;

  dtc_pingpong_ctrl #(
    .WORD_BITS(WB),
    .NUM_WORDS(NW),
    .ADDR_W(AW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .bram_en(bram_en),
    .bram_addr(bram_addr),
    .ser_load(ser_load),
    .ser_shift(ser_shift),
    .wr_en_0(wr_en_0),
    .wr_en_1(wr_en_1),
    .rd_en_0(rd_en_0),
    .rd_en_1(rd_en_1),
    .full_0(full_0),
    .empty_0(empty_0),
    .full_1(full_1),
    .empty_1(empty_1),
    .out_sel(out_sel),
    .out_valid(out_valid),
    .frame_done(frame_done),
    .fill_bank(fill_bank),
    .ovf_err(ovf_err),
    .udf_err(udf_err)
  );

  logic [14:0] all_outs;
  assign all_outs = {bram_en, bram_addr, ser_load, ser_shift, wr_en_0, wr_en_1,
                     rd_en_0, rd_en_1, out_sel, out_valid, frame_done, fill_bank,
                     ovf_err, udf_err};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // BRAM model: word k holds 8'hA0+k, one-cycle read latency
  logic [WB-1:0] douta;
  always @(posedge clk) if (bram_en) douta <= 8'hA0 + 8'(bram_addr);

  // Serializer model: parallel load, shift toward bit 0
  logic [WB-1:0] ser_reg;
  always @(posedge clk or posedge rst)
    if (rst) ser_reg <= '0;
    else if (ser_load) ser_reg <= douta;
    else if (ser_shift) ser_reg <= {1'b0, ser_reg[WB-1:1]};

  // FIFO bank 0 model, depth 8, registered read data
  logic [7:0] mem0, mem1;
  logic [2:0] wp0, rp0, wp1, rp1;
  logic [3:0] cnt0, cnt1;
  logic       dout0, dout1;
  always @(posedge clk or posedge rst)
    if (rst) begin
      wp0 <= '0; rp0 <= '0; cnt0 <= '0; dout0 <= 1'b0;
    end else begin
      if (wr_en_0 && cnt0 != 4'd8) begin mem0[wp0] <= ser_reg[0]; wp0 <= wp0 + 3'd1; end
      if (rd_en_0 && cnt0 != 4'd0) begin dout0 <= mem0[rp0]; rp0 <= rp0 + 3'd1; end
      cnt0 <= cnt0 + 4'(wr_en_0 && cnt0 != 4'd8) - 4'(rd_en_0 && cnt0 != 4'd0);
    end

  // FIFO bank 1 model
  always @(posedge clk or posedge rst)
    if (rst) begin
      wp1 <= '0; rp1 <= '0; cnt1 <= '0; dout1 <= 1'b0;
    end else begin
      if (wr_en_1 && cnt1 != 4'd8) begin mem1[wp1] <= ser_reg[0]; wp1 <= wp1 + 3'd1; end
      if (rd_en_1 && cnt1 != 4'd0) begin dout1 <= mem1[rp1]; rp1 <= rp1 + 3'd1; end
      cnt1 <= cnt1 + 4'(wr_en_1 && cnt1 != 4'd8) - 4'(rd_en_1 && cnt1 != 4'd0);
    end

  assign full_0  = (cnt0 == 4'd8) || force_full0;
  assign empty_0 = (cnt0 == 4'd0);
  assign full_1  = (cnt1 == 4'd8);
  assign empty_1 = (cnt1 == 4'd0) || force_empty1;

  logic line_bit;
  assign line_bit = out_sel ? dout1 : dout0;

  // Event recorder: edge indices relative to base, reassembled serial bytes
  int   fetch_q[$], load_q[$], rd_q[$], ov_q[$], done_q[$], byte_q[$];
  int   ov_cnt = 0;
  int   coll   = 0;
  int   bit_cnt = 0;
  logic [7:0] byte_acc = '0;
  logic rd_prev = 1'b0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rd_prev <= 1'b0;
      ov_prev <= 1'b0;
      bit_cnt <= 0;
    end else begin
      if (bram_en) fetch_q.push_back(int'(bram_addr));
      if (ser_load) load_q.push_back(edge_cnt - base);
      if ((rd_en_0 | rd_en_1) && !rd_prev) rd_q.push_back(edge_cnt - base);
      if (out_valid && !ov_prev) ov_q.push_back(edge_cnt - base);
      if (frame_done) done_q.push_back(edge_cnt - base);
      if (out_valid) begin
        ov_cnt   <= ov_cnt + 1;
        byte_acc <= {line_bit, byte_acc[7:1]};
        bit_cnt  <= bit_cnt + 1;
        if (bit_cnt == 7) begin
          byte_q.push_back(int'({line_bit, byte_acc[7:1]}));
          bit_cnt <= 0;
        end
      end
      if ((wr_en_0 && rd_en_0) || (wr_en_1 && rd_en_1)) coll <= coll + 1;
      rd_prev <= rd_en_0 | rd_en_1;
      ov_prev <= out_valid;
    end
  end

  function automatic int qget(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    check_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic waitEdge(input int k);
    while (edge_cnt < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goTo(input int k);
    waitEdge(k);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int k, input logic en, input logic ff0, input logic fe1);
    waitEdge(k);
    enable       = en;
    force_full0  = ff0;
    force_empty1 = fe1;
  endtask

  int exp_addr [5] = '{0, 1, 2, 0, 1};
  int exp_byte [5] = '{32'hA0, 32'hA1, 32'hA2, 32'hA0, 32'hA1};
  int f_idx, l_idx, r_idx, o_idx, d_idx;

  initial begin
    $display("[TB] start");
    rst = 1'b1; enable = 1'b1; force_full0 = 1'b0; force_empty1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'(all_outs), 32'd0);
    checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = edge_cnt;

    // Enable held from reset: load two cycles after, first write one cycle later
    goTo(2);
    checkOutput("load_latency", 32'(ser_load), 32'd1);
    checkOutput("no_wr_in_load", 32'(wr_en_0), 32'd0);
    goTo(3);
    checkOutput("first_wr_en", 32'(wr_en_0), 32'd1);

    // Drop enable mid-FILL of the word at address 1 (fifth frame)
    applyStimulus(45, 1'b0, 1'b0, 1'b0);
    goTo(61);
    checkOutput("idle_after_flush", 32'(dut.state), 32'(IDLE));
    checkOutput("addr_after_flush", 32'(bram_addr), 32'd2);
    checkOutput("bank_after_flush", 32'(fill_bank), 32'd1);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("fetch_addr%0d", i), qget(fetch_q, i), exp_addr[i]);
      checkOutput($sformatf("byte%0d", i), qget(byte_q, i), exp_byte[i]);
    end
    checkOutput("load_edge0", qget(load_q, 0), 32'd2);
    checkOutput("load_edge1", qget(load_q, 1), 32'd12);
    checkOutput("load_edge4", qget(load_q, 4), 32'd42);
    checkOutput("first_rd_en", qget(rd_q, 0), 32'd13);
    checkOutput("first_out_valid", qget(ov_q, 0), 32'd14);
    checkOutput("frame_done0", qget(done_q, 0), 32'd22);
    checkOutput("frame_done_flush", qget(done_q, 4), 32'd60);
    checkOutput("valid_bits_total", ov_cnt, 32'd40);

    // Re-enable: next fetch from address 2, first frame drains nothing
    applyStimulus(62, 1'b1, 1'b0, 1'b0);
    goTo(75);
    checkOutput("drain_bank1_active", 32'(rd_en_1), 32'd1);
    #1;
    checkOutput("restart_addr", qget(fetch_q, 5), 32'd2);
    checkOutput("no_drain_first_frame", ov_cnt, 32'd40);

    // Empty bank 1 mid-drain: read suppressed, underflow sticks
    applyStimulus(76, 1'b1, 1'b0, 1'b1);
    goTo(76);
    checkOutput("udf_rd_blocked", 32'(rd_en_1), 32'd0);
    checkOutput("udf_shift_on", 32'(ser_shift), 32'd1);
    goTo(77);
    checkOutput("udf_err_set", 32'(udf_err), 32'd1);
    checkOutput("ovf_err_clear", 32'(ovf_err), 32'd0);
    applyStimulus(79, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a FILL
    waitEdge(87);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", 32'(all_outs), 32'd0);
    checkOutput("async_rst_state", 32'(dut.state), 32'(IDLE));
    f_idx = fetch_q.size(); l_idx = load_q.size(); r_idx = rd_q.size();
    o_idx = ov_q.size();    d_idx = done_q.size();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = edge_cnt;

    // Restart repeats the first-run timing; then overflow on bank 0 (third frame)
    goTo(24);
    checkOutput("ovf_wr_before", 32'(wr_en_0), 32'd1);
    applyStimulus(25, 1'b1, 1'b1, 1'b0);
    goTo(25);
    checkOutput("ovf_wr_blocked", 32'(wr_en_0), 32'd0);
    checkOutput("ovf_shift_on", 32'(ser_shift), 32'd1);
    goTo(26);
    checkOutput("ovf_err_set", 32'(ovf_err), 32'd1);
    applyStimulus(28, 1'b1, 1'b0, 1'b0);
    goTo(30);
    #1;
    checkOutput("rst_fetch_addr", qget(fetch_q, f_idx), 32'd0);
    checkOutput("rst_load_edge", qget(load_q, l_idx), 32'd2);
    checkOutput("rst_first_rd_en", qget(rd_q, r_idx), 32'd13);
    checkOutput("rst_first_out_valid", qget(ov_q, o_idx), 32'd14);
    checkOutput("rst_frame_done", qget(done_q, d_idx), 32'd22);
    goTo(40);
    checkOutput("ovf_err_sticky", 32'(ovf_err), 32'd1);
    waitEdge(41);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("ovf_err_rst", 32'(ovf_err), 32'd0);
    checkOutput("final_rst_outputs", 32'(all_outs), 32'd0);
    checkOutput("bank_collisions", coll, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
